// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads the sysid ID and timestamp words after start and flags any mismatch.
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   start                   - single-cycle request; ignored while busy
//   sysid_address           - word select to the sysid slave (0 = ID, 1 = timestamp)
//   sysid_readdata          - slave read data, sampled only on capture edges
//   busy, done              - sequence in progress / result valid
//   id_ok, ts_ok            - per-word match flags, valid while done
//   captured_id/_ts         - last captured words
//   error_count             - saturating count of sequences with any mismatch
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'hDEADBEEF,
    parameter logic [31:0] EXPECTED_TS  = 32'd1536547189,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  error_count
);
    localparam logic [1:0] LAT = 2'(READ_LATENCY);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        addr_q, addr_d, busy_q, busy_d, done_q, done_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
    logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
    logic [7:0]  err_q, err_d;
    logic        wait_over, id_match, ts_match;
    assign wait_over = cnt_q == LAT;
    assign id_match  = cap_id_q == EXPECTED_ID;
    assign ts_match  = sysid_readdata == EXPECTED_TS;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        cap_id_d = cap_id_q;
        cap_ts_d = cap_ts_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RD_ID;
                addr_d  = 1'b0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                id_ok_d = 1'b0;
                ts_ok_d = 1'b0;
                cnt_d   = 2'd0;
            end
            RD_ID: if (wait_over) begin
                cap_id_d = sysid_readdata;
                addr_d   = 1'b1;
                cnt_d    = 2'd0;
                state_d  = RD_TS;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            RD_TS: if (wait_over) begin
                cap_ts_d = sysid_readdata;
                id_ok_d  = id_match;
                ts_ok_d  = ts_match;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                addr_d   = 1'b0;
                state_d  = DONE;
                // saturate at 255 rather than wrap
                err_d    = (!(id_match && ts_match) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            cap_id_q <= 32'd0;
            cap_ts_q <= 32'd0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            cap_id_q <= cap_id_d;
            cap_ts_q <= cap_ts_d;
            err_q    <= err_d;
        end
    end
    assign sysid_address = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign captured_id   = cap_id_q;
    assign captured_ts   = cap_ts_q;
    assign error_count   = err_q;
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: directed checks of sysid_boot_checker at read latency 0 and 3.
module tb_sysid_boot_checker;
    localparam logic [31:0] GOOD_ID = 32'hDEADBEEF;
    localparam logic [31:0] GOOD_TS = 32'd1536547189;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start3 = 1'b0;
    logic [31:0] id_val = GOOD_ID, ts_val = GOOD_TS, rd0, rd3 = 32'h0;
    logic        addr0, busy0, done0, id_ok0, ts_ok0;
    logic        addr3, busy3, done3, id_ok3, ts_ok3;
    logic [31:0] cid0, cts0, cid3, cts3;
    logic [7:0]  err0, err3;
    int          checks = 0, errors = 0;
    always #5 clock = ~clock;
    assign rd0 = addr0 ? ts_val : id_val;
    sysid_boot_checker #(.READ_LATENCY(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .sysid_address(addr0),
        .sysid_readdata(rd0), .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0),
        .captured_id(cid0), .captured_ts(cts0), .error_count(err0)
    );
    sysid_boot_checker #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start3), .sysid_address(addr3),
        .sysid_readdata(rd3), .busy(busy3), .done(done3), .id_ok(id_ok3), .ts_ok(ts_ok3),
        .captured_id(cid3), .captured_ts(cts3), .error_count(err3)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    // one complete latency-0 sequence with start held for hold cycles
    task automatic seq0(input int hold);
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i + 1 >= hold) start0 = 1'b0;
        end
    endtask
    initial begin
        repeat (3) tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_cid", cid0, 0);
        check("rst_err", err0, 0);
        check("rst3_addr", addr3, 0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy0, 0);
        // latency 0, correct data
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("l0_busy", busy0, 1);
        check("l0_done_e1", done0, 0);
        check("l0_addr_e1", addr0, 0);
        tick();
        check("l0_addr_e2", addr0, 1);
        check("l0_cid", cid0, GOOD_ID);
        check("l0_done_e2", done0, 0);
        tick();
        check("l0_done", done0, 1);
        check("l0_busy_end", busy0, 0);
        check("l0_id_ok", id_ok0, 1);
        check("l0_ts_ok", ts_ok0, 1);
        check("l0_cts", cts0, GOOD_TS);
        check("l0_err", err0, 0);
        check("l0_addr_end", addr0, 0);
        tick();
        check("l0_hold_done", done0, 1);
        // bad ID, started from DONE
        id_val = 32'hDEADBEEE;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("bid_done_clr", done0, 0);
        check("bid_idok_clr", id_ok0, 0);
        check("bid_cid_keep", cid0, GOOD_ID);
        tick();
        check("bid_cid_new", cid0, 32'hDEADBEEE);
        tick();
        check("bid_done", done0, 1);
        check("bid_id_ok", id_ok0, 0);
        check("bid_ts_ok", ts_ok0, 1);
        check("bid_err", err0, 1);
        // bad timestamp only
        id_val = GOOD_ID;
        ts_val = GOOD_TS ^ 32'h8000_0000;
        seq0(1);
        check("bts_id_ok", id_ok0, 1);
        check("bts_ts_ok", ts_ok0, 0);
        check("bts_err", err0, 2);
        // start held high throughout: one sequence, same timing
        id_val = 32'h0;
        ts_val = GOOD_TS;
        start0 = 1'b1;
        tick();
        tick();
        check("rep_done_e2", done0, 0);
        check("rep_busy_e2", busy0, 1);
        start0 = 1'b0;
        tick();
        check("rep_done", done0, 1);
        check("rep_err", err0, 3);
        tick();
        check("rep_single", busy0, 0);
        // saturation
        for (int n = 0; n < 251; n++) seq0(1);
        check("sat_254", err0, 254);
        seq0(1);
        check("sat_255", err0, 255);
        for (int n = 0; n < 48; n++) seq0(1);
        check("sat_hold", err0, 255);
        // latency 3: good data only on capture edges
        start3 = 1'b1;
        rd3 = 32'h0BAD_F00D;
        tick();
        start3 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            rd3 = (k == 4) ? GOOD_ID : (k == 8) ? GOOD_TS : 32'h0BAD_F00D ^ k;
            tick();
            if (k == 3) check("l3_addr_e3", addr3, 0);
            if (k == 4) check("l3_addr_e4", addr3, 1);
            if (k == 4) check("l3_cid", cid3, GOOD_ID);
            if (k == 7) check("l3_done_e7", done3, 0);
        end
        rd3 = 32'h1234_5678;
        check("l3_done", done3, 1);
        check("l3_id_ok", id_ok3, 1);
        check("l3_ts_ok", ts_ok3, 1);
        check("l3_err", err3, 0);
        // reset mid RD_TS on latency 0
        id_val = GOOD_ID;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("ar_busy", busy0, 0);
        check("ar_addr", addr0, 0);
        check("ar_cid", cid0, 0);
        check("ar_err", err0, 0);
        check("ar_done", done0, 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("ar_idle_done", done0, 0);
        check("ar_idle_busy", busy0, 0);
        seq0(1);
        check("ar_new_done", done0, 1);
        check("ar_new_ok", {id_ok0, ts_ok0}, 2'b11);
        check("ar_new_err", err0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysid_boot_checker.md
SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'hDEADBEEF, value required at sysid word 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1536547189, value required at sysid word 1 (build timestamp).
REQ-003 Parameter READ_LATENCY, default 0, range 0..3, slave read latency in cycles.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to run one check sequence.
REQ-007 sysid_address  output  1  registered word select to the sysid slave (0 = ID, 1 = timestamp).
REQ-008 sysid_readdata  input  32  read data returned by the sysid slave.
REQ-009 busy  output  1  high while a check sequence is in progress.
REQ-010 done  output  1  high from sequence completion until the next accepted start or reset.
REQ-011 id_ok  output  1  captured ID equals EXPECTED_ID; valid while done.
REQ-012 ts_ok  output  1  captured timestamp equals EXPECTED_TS; valid while done.
REQ-013 captured_id  output  32  last captured word 0.
REQ-014 captured_ts  output  32  last captured word 1.
REQ-015 error_count  output  8  number of completed sequences with any mismatch, saturating.

Function
REQ-016 FSM states: IDLE, RD_ID, RD_TS, DONE; all outputs registered.
REQ-017 IDLE or DONE with start=1 at an edge -> RD_ID, sysid_address<=0, busy<=1, done<=0, id_ok<=0, ts_ok<=0, wait counter<=0.
REQ-018 start while busy=1 is ignored, no queuing.
REQ-019 RD_ID: wait counter increments each edge; at the edge where counter == READ_LATENCY, captured_id<=sysid_readdata, sysid_address<=1, counter<=0, -> RD_TS.
REQ-020 RD_TS: identical wait; at counter == READ_LATENCY, captured_ts<=sysid_readdata, id_ok<=(captured_id==EXPECTED_ID), ts_ok<=(sysid_readdata==EXPECTED_TS), done<=1, busy<=0, sysid_address<=0, -> DONE.
REQ-021 Latency: done rises at the 2*(READ_LATENCY+1)-th edge after the edge accepting start (2 edges for READ_LATENCY=0).
REQ-022 readdata is sampled only at REQ-019/REQ-020 capture edges; values at other times have no effect.
REQ-023 Comparisons are full 32-bit equality, no masking.
REQ-024 At the REQ-020 edge, if either comparison fails, error_count increments by 1 and holds at 255 (no wrap).
REQ-025 DONE holds done, id_ok, ts_ok, captured_id, captured_ts, and error_count stable until the next accepted start.
REQ-026 A new start from DONE clears done/id_ok/ts_ok but keeps captured_id, captured_ts, and error_count until overwritten.
REQ-027 Wait counter width: 2 bits; never exceeds READ_LATENCY.

Reset
REQ-028 reset_n=0 asynchronously forces IDLE, sysid_address=0, busy=0, done=0, id_ok=0, ts_ok=0, captured_id=0, captured_ts=0, error_count=0, counter=0.
REQ-029 Reset asserted mid-sequence aborts it; no partial result is reported and error_count is not incremented.
REQ-030 After reset_n deasserts, the block stays in IDLE until a start is sampled; start on the deassertion edge is honoured only if reset_n is high at that edge.

Verification
REQ-031 L=0, slave returns 0xDEADBEEF/1536547189 per address, start pulse -> done=1 two edges later, id_ok=1, ts_ok=1, error_count=0.
REQ-032 L=0, slave returns 0xDEADBEEE for word 0 -> done=1, id_ok=0, ts_ok=1, captured_id=0xDEADBEEE, error_count=1.
REQ-033 L=3, correct data valid only on capture edges, garbage otherwise -> done at edge 8 after start, id_ok=ts_ok=1.
REQ-034 start re-pulsed every cycle during a sequence -> single sequence, done timing unchanged; 300 failing sequences -> error_count=255.
REQ-035 reset_n pulsed low during RD_TS -> all outputs 0 immediately, state IDLE, no done; next start completes normally.
REQ-036 start asserted in DONE -> done drops next edge, captured_id retained until the new RD_ID capture.
